// File: rtl/intr_ctrl_pkg.sv
// ============================================================================
// Module : intr_ctrl_pkg
// Brief  : Register map, CAUSE layout and FSM encodings for intr_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package intr_ctrl_pkg;

    // Byte offsets of the MMIO registers; only bits [3:2] are decoded
    localparam logic [3:0] INTC_PENDING = 4'h0;
    localparam logic [3:0] INTC_MASK    = 4'h4;
    localparam logic [3:0] INTC_CAUSE   = 4'h8;
    localparam logic [3:0] INTC_CTRL    = 4'hC;

    localparam int CAUSE_VALID_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_t;

endpackage

`default_nettype wire

// File: rtl/intr_prio_enc.sv
// ============================================================================
// Module : intr_prio_enc
// Brief  : Combinational priority encoder, lowest set index wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module intr_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [ID_W-1:0]    id
);

    // Scanning downwards lets the lowest set index overwrite higher ones
    always_comb begin
        any = |req;
        id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ============================================================================
// Module : intr_ctrl
// Brief  : MMIO interrupt controller feeding the CP0 interrupt input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               reg_en,
    input  logic               reg_we,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    input  logic               cpu_eret,
    output logic               ir_out
);

    logic [NUM_SRC-1:0] sync1, sync2, hist;
    logic [NUM_SRC-1:0] pending, mask;
    logic [NUM_SRC-1:0] rise, clr, active;
    logic               gie;
    logic               cause_valid;
    logic [ID_W-1:0]    cause_id;
    logic               any;
    logic [ID_W-1:0]    prio_id;
    logic               take;
    logic               wr, rd;
    logic [3:0]         addr_off;
    logic [31:0]        rd_word;
    logic [31:0]        cause_word;
    logic               unused;
    intc_state_t        state, state_nxt;

    assign addr_off = {reg_addr[3:2], 2'b00};
    assign wr       = reg_en & reg_we;
    assign rd       = reg_en & ~reg_we;
    assign rise     = sync2 & ~hist;
    assign clr      = (wr && addr_off == INTC_PENDING) ? reg_wdata[NUM_SRC-1:0] : '0;
    assign active   = pending & mask;
    assign unused   = ^{reg_addr[1:0], reg_wdata};

    intr_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .req (active),
        .any (any),
        .id  (prio_id)
    );

    always_comb begin
        cause_word                  = '0;
        cause_word[CAUSE_VALID_BIT] = cause_valid;
        cause_word[ID_W-1:0]        = cause_id;
        case (addr_off)
            INTC_PENDING: rd_word = 32'(pending);
            INTC_MASK:    rd_word = 32'(mask);
            INTC_CAUSE:   rd_word = cause_word;
            INTC_CTRL:    rd_word = {31'b0, gie};
            default:      rd_word = '0;
        endcase
    end

    // A new edge wins over a simultaneous W1C so no event is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            hist      <= '0;
            pending   <= '0;
            mask      <= '0;
            gie       <= 1'b0;
            reg_rdata <= '0;
        end else begin
            sync1   <= src_in;
            sync2   <= sync1;
            hist    <= sync2;
            pending <= (pending & ~clr) | rise;
            if (wr && addr_off == INTC_MASK) begin
                mask <= reg_wdata[NUM_SRC-1:0];
            end
            if (wr && addr_off == INTC_CTRL) begin
                gie <= reg_wdata[0];
            end
            if (rd) begin
                reg_rdata <= rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cause_valid <= 1'b0;
            cause_id    <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                cause_valid <= 1'b1;
                cause_id    <= prio_id;
            end else if (state == ST_SERVICE && state_nxt == ST_IDLE) begin
                cause_valid <= 1'b0;
                cause_id    <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ir_out    = 1'b0;
        take      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gie && any) begin
                    state_nxt = ST_ASSERT;
                    take      = 1'b1;
                end
            end
            ST_ASSERT: begin
                ir_out    = 1'b1;
                state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (cpu_eret) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire
